// File: rtl/alu_counter_pkg.sv
// Shared constants for the counter slice: saturation modes, default width,
// and the per-edge operation decode used by updown_counter.
package alu_counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SAT      = 1;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLR   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_COUNT = 2'd3
  } op_e;

  // Resolve the per-edge operation: clear beats load, load beats count.
  function automatic op_e decode_op(input logic clr, input logic load, input logic en);
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (en)   return OP_COUNT;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/toggle_cell.sv
// One bit of the count register: a toggle flop with a synchronous load
// that overrides the toggle, and an asynchronous active-low reset to 0.
module toggle_cell (
  input  logic clk,
  input  logic resetn,
  input  logic ld_val,
  input  logic ld,
  input  logic tgl,
  output logic q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   q <= 1'b0;
    else if (ld)   q <= ld_val;
    else if (tgl)  q <= ~q;
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with programmable modulus, wrap or saturate at the bounds,
// combinational terminal count and a registered one-cycle boundary pulse.
module updown_counter
  import alu_counter_pkg::*;
#(
  parameter int              WIDTH     = DEFAULT_WIDTH,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter: WIDTH %0d outside 2..32", WIDTH);
  end
  if (MAX_VALUE < 64'd1 || MAX_VALUE > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("updown_counter: MAX_VALUE %0d outside 1..2**WIDTH-1", MAX_VALUE);
  end

  localparam logic [WIDTH-1:0] MAXV = MAX_VALUE[WIDTH-1:0];

  op_e              op;
  logic             at_max;
  logic             at_min;
  logic             boundary;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] ld_value;
  logic [WIDTH-1:0] tgl;
  logic             ld_all;
  logic             ones;
  logic             zeros;

  assign op       = decode_op(clr, load, en);
  assign at_max   = (q == MAXV);
  assign at_min   = (q == '0);
  assign tc       = en & ((up & at_max) | (~up & at_min));
  assign boundary = (op == OP_COUNT) & tc;

  // Bit i toggles when every lower bit is 1 (counting up) or 0 (counting down).
  always_comb begin
    ones  = 1'b1;
    zeros = 1'b1;
    carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = up ? ones : zeros;
      ones     = ones & q[i];
      zeros    = zeros & ~q[i];
    end
  end

  // Wrap uses the load path since the modulus need not be a power of two.
  always_comb begin
    ld_all   = 1'b0;
    ld_value = '0;
    tgl      = '0;
    case (op)
      OP_CLR: begin
        ld_all   = 1'b1;
        ld_value = '0;
      end
      OP_LOAD: begin
        ld_all   = 1'b1;
        ld_value = (din > MAXV) ? MAXV : din;
      end
      OP_COUNT: begin
        if (boundary) begin
          if (SATURATE == MODE_WRAP) begin
            ld_all   = 1'b1;
            ld_value = up ? '0 : MAXV;
          end
        end else begin
          tgl = carry;
        end
      end
      default: begin
        ld_all = 1'b0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    toggle_cell u_cell (
      .clk    (clk),
      .resetn (resetn),
      .ld_val (ld_value[i]),
      .ld     (ld_all),
      .tgl    (tgl[i]),
      .q      (q[i])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovf <= 1'b0;
    else         ovf <= boundary;
  end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three WIDTH=4 instances (wrap/15, saturate/15,
// wrap/9) share one stimulus stream and are checked against an arithmetic model.
module tb_updown_counter;

  localparam int W = 4;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic [W-1:0] q_w [N];
  logic         tc_w [N];
  logic         ovf_w [N];

  int n_cmp = 0;
  int n_fail = 0;

  int mx  [N] = '{15, 15, 9};
  int sat [N] = '{0, 1, 0};
  int m_q [N];
  int m_ovf [N];
  logic [W-1:0] exp_q [$];

  // Clock and reset
  always #5 clk = ~clk;

  updown_counter #(.WIDTH(W), .MAX_VALUE(15), .SATURATE(0)) u_wrap15 (
    .clk(clk), .resetn(resetn), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .q(q_w[0]), .tc(tc_w[0]), .ovf(ovf_w[0]));
  updown_counter #(.WIDTH(W), .MAX_VALUE(15), .SATURATE(1)) u_sat15 (
    .clk(clk), .resetn(resetn), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .q(q_w[1]), .tc(tc_w[1]), .ovf(ovf_w[1]));
  updown_counter #(.WIDTH(W), .MAX_VALUE(9), .SATURATE(0)) u_wrap9 (
    .clk(clk), .resetn(resetn), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .q(q_w[2]), .tc(tc_w[2]), .ovf(ovf_w[2]));

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d]: observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  // Model: next count from the rules, using modular arithmetic for wrap.
  function automatic int model_next(input int k, input int cur);
    int m;
    m = mx[k];
    if (clr)  return 0;
    if (load) return (int'(din) > m) ? m : int'(din);
    if (!en)  return cur;
    if (up) begin
      if (cur == m && sat[k] == 1) return m;
      return (cur + 1) % (m + 1);
    end
    if (cur == 0 && sat[k] == 1) return 0;
    return (cur + m) % (m + 1);
  endfunction

  function automatic int model_tc(input int k);
    return (en && ((up && m_q[k] == mx[k]) || (!up && m_q[k] == 0))) ? 1 : 0;
  endfunction

  // One clock edge: called one time unit after a rising edge with inputs set.
  task automatic step();
    #1;
    for (int k = 0; k < N; k++) chk("tc", k, 32'(tc_w[k]), 32'(model_tc(k)));
    for (int k = 0; k < N; k++) begin
      m_ovf[k] = (!clr && !load && model_tc(k) == 1) ? 1 : 0;
      m_q[k]   = model_next(k, m_q[k]);
      exp_q.push_back(W'(m_q[k]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk("q", k, 32'(q_w[k]), 32'(exp_q.pop_front()));
      chk("ovf", k, 32'(ovf_w[k]), 32'(m_ovf[k]));
    end
  endtask

  task automatic drive(input logic c, input logic l, input int d, input logic e, input logic u);
    clr = c; load = l; din = W'(d); en = e; up = u;
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < N; k++) begin
      m_q[k] = 0;
      m_ovf[k] = 0;
      chk({tag, "_q"}, k, 32'(q_w[k]), 32'd0);
      chk({tag, "_ovf"}, k, 32'(ovf_w[k]), 32'd0);
    end
  endtask

  initial begin
    // Reset held across edges with busy inputs that must be ignored
    drive(1'b0, 1'b1, 7, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    resetn = 1'b1;

    // Count up 20 edges from 0
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    repeat (20) step();

    // Load 2, then count down through 0
    drive(1'b0, 1'b1, 2, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (5) step();

    // Modulus edges: 8 -> 9 -> wrap, load clamp, down from 0
    drive(1'b0, 1'b1, 8, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    repeat (2) step();
    drive(1'b0, 1'b1, 12, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (2) step();

    // Priority: clr over load over en
    drive(1'b1, 1'b1, 7, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b1, 7, 1'b1, 1'b1);
    step();

    // Async reset mid-cycle while counting from 11
    drive(1'b0, 1'b1, 11, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    step();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    resetn = 1'b1;
    repeat (3) step();

    // Direction flip every edge from 5
    drive(1'b0, 1'b1, 5, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
      step();
    end

    // Randomized traffic, biased toward counting so bounds are reached
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 7) < 5) ? 1'b1 : 1'b0);
      step();
    end

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
